sha256_msg_sched: RTL
=====================

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: block_in holds a valid 512-bit padded message block.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a new message block.
REQ-005 SHALL have port block_in, input, 512 bits: message block, big-endian; word 0 = bits [511:480], word 15 = bits [31:0].
REQ-006 SHALL have port W, output, 64x32 bits, packed [0:63][31:0]: expanded message schedule, word 0 first; feeds the compression round engine directly.
REQ-007 SHALL have port out_valid, output, 1 bit: W[0..63] complete and stable.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts W this cycle.
REQ-009 SHALL have port busy, output, 1 bit: high in EXPAND and HOLD.

Function
REQ-010 SHALL implement FSM states IDLE, EXPAND, HOLD.
REQ-011 SHALL drive in_ready = 1 only in IDLE, and busy = 1 only in EXPAND or HOLD.
REQ-012 SHALL, in IDLE with in_valid=1 (accept), load W[i] = block_in word i for i=0..15, clear W[16..63] to 0, set idx=16, and go to EXPAND.
REQ-013 SHALL hold a 6-bit index idx that writes exactly one word per cycle in EXPAND.
REQ-014 SHALL compute, each EXPAND cycle, W[idx] = s1(W[idx-2]) + W[idx-7] + s0(W[idx-15]) + W[idx-16], modulo 2^32, with carries discarded.
REQ-015 SHALL define s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-016 SHALL define s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-017 SHALL, in the cycle it writes idx=63, go to HOLD and not wrap idx; exactly 48 expansion cycles occur.
REQ-018 SHALL assert out_valid in the first HOLD cycle: accept edge at cycle T gives out_valid=1 at cycle T+49.
REQ-019 SHALL keep out_valid=1 and all of W unchanged in HOLD until out_ready=1 is sampled.
REQ-020 SHALL, in HOLD with out_ready=1, go to IDLE, drop out_valid next cycle, and retain W contents.
REQ-021 SHALL drive out_valid = 0 outside HOLD; out_ready outside HOLD SHALL be ignored.
REQ-022 SHALL ignore in_valid and block_in outside IDLE; no input buffering.
REQ-023 SHALL not modify W[0..15] during EXPAND or HOLD.
REQ-024 SHALL require no combinational path from in_valid or out_ready to in_ready or out_valid.
REQ-025 SHALL, for a new accept immediately after a HOLD->IDLE transition, overwrite W per REQ-012; the minimum block-to-block interval is 50 cycles with out_ready held high.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, enter IDLE, clear W[0..63] to 0, and set idx=0.
REQ-027 SHALL drive out_valid=0, busy=0, and in_ready=1 on the cycle after reset.
REQ-028 SHALL let reset override every state, including mid-EXPAND and HOLD; any partial schedule is discarded.
REQ-029 SHALL ignore in_valid during the reset cycle.

Verification
REQ-030 SHALL cover this scenario: "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018) accepted at T -> out_valid at T+49; W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[63]=0x12B1EDEB.
REQ-031 SHALL cover this scenario: all-zero block -> W[0..63] all 0x00000000; out_valid exactly at T+49; busy high from T+1 to T+49 inclusive.
REQ-032 SHALL cover this scenario: backpressure with out_ready=0 for 10 cycles after out_valid -> W bit-identical each cycle, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
REQ-033 SHALL cover this scenario: reset asserted while idx=30 -> next cycle IDLE, in_ready=1, out_valid=0, all W=0; a new "abc" accept then reproduces the REQ-030 values.
REQ-034 SHALL cover this scenario: two back-to-back blocks with out_ready tied 1 -> second accept 50 cycles after the first; second schedule correct, and the first block's W is not visible after the second accept.
REQ-035 SHALL cover this scenario: arithmetic wrap with block words all 0xFFFFFFFF -> W[16] = s1(0xFFFFFFFF)+0xFFFFFFFF+s0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32, compared against a reference model.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander: loads a 512-bit block, then produces
// W[16..63] one word per cycle and holds the full schedule until consumed.
module sha256_msg_sched (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [511:0]      block_in,
    output logic [0:63][31:0] W,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

    state_t            state_q;
    logic [5:0]        idx_q;
    logic [0:63][31:0] w_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [0:15][31:0] blk_words;
    logic [31:0]       w_m2, w_m7, w_m15, w_m16;
    logic [31:0]       new_word_d;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Word 0 sits in the most significant 32 bits of the block.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_blk
            assign blk_words[gi] = block_in[511 - 32*gi -: 32];
        end
    endgenerate

    // idx_q is always >= 16 while expanding, so the taps never underflow.
    always_comb begin
        w_m2       = w_q[idx_q - 6'd2];
        w_m7       = w_q[idx_q - 6'd7];
        w_m15      = w_q[idx_q - 6'd15];
        w_m16      = w_q[idx_q - 6'd16];
        new_word_d = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 6'd0;
            w_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q        <= {blk_words, {48{32'h0}}};
                        idx_q      <= 6'd16;
                        state_q    <= EXPAND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                EXPAND: begin
                    w_q[idx_q] <= new_word_d;
                    if (idx_q == 6'd63) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign W         = w_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
